// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> multi-cycle datapath bundle: opcode/flags/memory-ready in, per-state controls out.
// The master modport is the control unit; the slave modport is the datapath/memory side.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 7,
  parameter int ALUOP_W  = 2
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic                mem_read;
  logic                mem_write;
  logic                iord;
  logic                ir_write;
  logic                pc_write;
  logic                pc_src;
  logic                alu_src;
  logic                mem_to_reg;
  logic                reg_write;
  logic [ALUOP_W-1:0]  alu_op;
  logic [2:0]          state;
  logic                illegal_op;
  logic                timeout_err;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src, mem_to_reg, reg_write, alu_op, state,
           illegal_op, timeout_err
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_write, pc_src,
           alu_src, mem_to_reg, reg_write, alu_op, state,
           illegal_op, timeout_err
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// RV32 multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT); define PERF_CNT_EN for retired_cnt.
// CPI with mem_ready high: branch 3, R/I 4, store 4, load 5; FETCH/MEM stall on mem_ready, HALT on timeout.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 7,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_unit_if.master  io_bus
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]           retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_I      = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_I   = ALUOP_W'(2'b11);

  localparam int              WAIT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);
  localparam logic            TMO_EN   = (MEM_TIMEOUT > 0);

  state_t              r_state;
  state_t              w_next;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [OPCODE_W-1:0] r_op_q;
  logic                r_illegal_op;
  logic                r_timeout_err;

  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_iord;
  logic                w_ir_write;
  logic                w_pc_write;
  logic                w_pc_src;
  logic                w_alu_src;
  logic                w_mem_to_reg;
  logic                w_reg_write;
  logic [ALUOP_W-1:0]  w_alu_op;
  logic                w_retire;
  logic                w_known;
  logic                w_waiting;
  logic                w_timeout;
  logic                w_op_load;
  logic                w_op_store;

  assign w_known = (io_bus.opcode == OP_R)     || (io_bus.opcode == OP_I)     ||
                   (io_bus.opcode == OP_LOAD)  || (io_bus.opcode == OP_STORE) ||
                   (io_bus.opcode == OP_BRANCH);

  assign w_op_load  = (r_op_q == OP_LOAD);
  assign w_op_store = (r_op_q == OP_STORE);

  // A stall cycle is any FETCH/MEM cycle where memory has not completed yet.
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !io_bus.mem_ready;
  assign w_timeout = TMO_EN && w_waiting && (r_wait_cnt == WAIT_LIM);

  always_comb begin
    w_next       = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_op     = ALU_ADD;
    w_retire     = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (io_bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end

      // Unknown opcodes fall back to FETCH; PC already advanced, so it acts as a NOP.
      S_DECODE: begin
        w_next = w_known ? S_EXEC : S_FETCH;
      end

      S_EXEC: begin
        case (r_op_q)
          OP_R: begin
            w_alu_op = ALU_R;
            w_next   = S_WB;
          end
          OP_I: begin
            w_alu_op  = ALU_I;
            w_alu_src = 1'b1;
            w_next    = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            w_alu_op  = ALU_ADD;
            w_alu_src = 1'b1;
            w_next    = S_MEM;
          end
          OP_BRANCH: begin
            w_alu_op   = ALU_SUB;
            w_pc_src   = 1'b1;
            w_pc_write = io_bus.zero;
            w_retire   = 1'b1;
            w_next     = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end

      S_MEM: begin
        w_iord      = 1'b1;
        w_mem_read  = w_op_load;
        w_mem_write = w_op_store;
        if (io_bus.mem_ready) begin
          w_retire = w_op_store;
          w_next   = w_op_load ? S_WB : S_FETCH;
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end

      S_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = w_op_load;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end

      S_HALT: w_next = S_HALT;

      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_wait_cnt    <= '0;
      r_op_q        <= '0;
      r_illegal_op  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;

      // Saturate so a disabled timeout never wraps the counter back to zero.
      if (w_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_waiting && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      if (r_state == S_DECODE) begin
        r_op_q <= io_bus.opcode;
        if (!w_known) begin
          r_illegal_op <= 1'b1;
        end
      end

      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
    end else if (w_retire) begin
      retired_cnt <= retired_cnt + 1'b1;
    end
  end
`endif

  // Reset forces every control low so an interrupted store/load cannot complete.
  assign io_bus.mem_read    = w_mem_read   & ~reset;
  assign io_bus.mem_write   = w_mem_write  & ~reset;
  assign io_bus.iord        = w_iord       & ~reset;
  assign io_bus.ir_write    = w_ir_write   & ~reset;
  assign io_bus.pc_write    = w_pc_write   & ~reset;
  assign io_bus.pc_src      = w_pc_src     & ~reset;
  assign io_bus.alu_src     = w_alu_src    & ~reset;
  assign io_bus.mem_to_reg  = w_mem_to_reg & ~reset;
  assign io_bus.reg_write   = w_reg_write  & ~reset;
  assign io_bus.alu_op      = reset ? ALU_ADD : w_alu_op;
  assign io_bus.state       = r_state;
  assign io_bus.illegal_op  = r_illegal_op;
  assign io_bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with MEM_TIMEOUT=4; checks state, controls and sticky flags.
// Retired-count checks are compiled in when PERF_CNT_EN is defined.
module tb_multicycle_control_unit;
  localparam int OPCODE_W    = 7;
  localparam int ALUOP_W     = 2;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  // Control vector bit positions: {mr,mw,iord,irw,pcw,pcs,as,m2r,rw,alu_op[1:0]}
  localparam logic [31:0] MR   = 32'h400;
  localparam logic [31:0] MW   = 32'h200;
  localparam logic [31:0] IORD = 32'h100;
  localparam logic [31:0] IRW  = 32'h080;
  localparam logic [31:0] PCW  = 32'h040;
  localparam logic [31:0] PCS  = 32'h020;
  localparam logic [31:0] AS   = 32'h010;
  localparam logic [31:0] M2R  = 32'h008;
  localparam logic [31:0] RW   = 32'h004;
  localparam logic [31:0] A_SUB = 32'h001;
  localparam logic [31:0] A_R   = 32'h002;
  localparam logic [31:0] A_I   = 32'h003;
  localparam logic [31:0] NONE  = 32'h000;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] exp_ret = 32'd0;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) bus ();

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] retired_cnt;
`endif

  multicycle_control_unit #(
    .OPCODE_W   (OPCODE_W),
    .ALUOP_W    (ALUOP_W),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
`ifdef PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  function automatic logic [31:0] ctl();
    return {21'd0, bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
            bus.pc_src, bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.alu_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag);
`ifdef PERF_CNT_EN
    chk(tag, 32'(retired_cnt), exp_ret);
`else
    n_vec = n_vec + 0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One FETCH cycle with memory ready, presenting the next opcode.
  task automatic fetch(input string tag, input logic [6:0] op);
    bus.mem_ready = 1'b1;
    bus.opcode    = op;
    #1;
    chk({tag, "_fetch_state"}, 32'(bus.state), 32'd0);
    chk({tag, "_fetch_ctl"}, ctl(), MR | IRW | PCW);
    tick();
    chk({tag, "_decode_state"}, 32'(bus.state), 32'd1);
    chk({tag, "_decode_ctl"}, ctl(), NONE);
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_ctl", ctl(), NONE);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_illegal", 32'(bus.illegal_op), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    chk_ret("rst_ret");
    reset = 1'b0;

    // R-type: 0,1,2,4,0
    fetch("r", OP_R);
    chk("r_exec_state", 32'(bus.state), 32'd2);
    chk("r_exec_ctl", ctl(), A_R);
    tick();
    chk("r_wb_state", 32'(bus.state), 32'd4);
    chk("r_wb_ctl", ctl(), RW);
    tick();
    chk("r_done_state", 32'(bus.state), 32'd0);
    exp_ret = exp_ret + 1;
    chk_ret("r_ret");

    // I-type ALU
    fetch("i", OP_I);
    chk("i_exec_ctl", ctl(), AS | A_I);
    tick();
    chk("i_wb_ctl", ctl(), RW);
    tick();
    chk("i_done_state", 32'(bus.state), 32'd0);
    exp_ret = exp_ret + 1;

    // Load with three MEM stall cycles
    fetch("ld", OP_LOAD);
    chk("ld_exec_ctl", ctl(), AS);
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'b0;
      #1;
      chk("ld_memwait_state", 32'(bus.state), 32'd3);
      chk("ld_memwait_ctl", ctl(), MR | IORD);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("ld_memdone_ctl", ctl(), MR | IORD);
    tick();
    chk("ld_wb_state", 32'(bus.state), 32'd4);
    chk("ld_wb_ctl", ctl(), RW | M2R);
    tick();
    chk("ld_done_state", 32'(bus.state), 32'd0);
    chk("ld_timeout", 32'(bus.timeout_err), 32'd0);
    exp_ret = exp_ret + 1;
    chk_ret("ld_ret");

    // Store, memory ready immediately
    fetch("st", OP_STORE);
    chk("st_exec_ctl", ctl(), AS);
    tick();
    chk("st_mem_ctl", ctl(), MW | IORD);
    tick();
    chk("st_done_state", 32'(bus.state), 32'd0);
    exp_ret = exp_ret + 1;
    chk_ret("st_ret");

    // Branch taken and not taken
    fetch("bz1", OP_BRANCH);
    bus.zero = 1'b1;
    #1;
    chk("bz1_exec_ctl", ctl(), PCS | PCW | A_SUB);
    tick();
    chk("bz1_done_state", 32'(bus.state), 32'd0);
    exp_ret = exp_ret + 1;
    fetch("bz0", OP_BRANCH);
    bus.zero = 1'b0;
    #1;
    chk("bz0_exec_ctl", ctl(), PCS | A_SUB);
    tick();
    chk("bz0_done_state", 32'(bus.state), 32'd0);
    exp_ret = exp_ret + 1;
    chk_ret("br_ret");

    // Illegal opcode is a NOP and sets the sticky flag
    chk("pre_illegal", 32'(bus.illegal_op), 32'd0);
    fetch("bad", OP_BAD);
    chk("bad_state", 32'(bus.state), 32'd0);
    chk("bad_illegal", 32'(bus.illegal_op), 32'd1);
    chk("bad_ctl", ctl(), MR | IRW | PCW);
    chk_ret("bad_ret");

    // mem_ready arriving on the limit cycle beats the timeout
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = 1'b0;
      bus.opcode    = OP_R;
      #1;
      chk("edge_wait_ctl", ctl(), MR);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("edge_fetch_ctl", ctl(), MR | IRW | PCW);
    tick();
    chk("edge_state", 32'(bus.state), 32'd1);
    chk("edge_timeout", 32'(bus.timeout_err), 32'd0);
    tick();
    tick();
    tick();
    chk("edge_done_state", 32'(bus.state), 32'd0);
    chk("illegal_sticky", 32'(bus.illegal_op), 32'd1);
    exp_ret = exp_ret + 1;
    chk_ret("edge_ret");

    // Reset during MEM of a store
    fetch("rs", OP_STORE);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("rs_mem_ctl", ctl(), MW | IORD);
    reset = 1'b1;
    #1;
    chk("rs_reset_ctl", ctl(), NONE);
    tick();
    chk("rs_after_state", 32'(bus.state), 32'd0);
    chk("rs_after_ctl", ctl(), NONE);
    chk("rs_illegal_clr", 32'(bus.illegal_op), 32'd0);
    exp_ret = 32'd0;
    chk_ret("rs_ret");
    reset = 1'b0;

    // Timeout: five FETCH wait cycles then HALT
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = 1'b0;
      #1;
      chk("tmo_wait_state", 32'(bus.state), 32'd0);
      chk("tmo_wait_ctl", ctl(), MR);
      tick();
    end
    chk("tmo_state", 32'(bus.state), 32'd5);
    chk("tmo_flag", 32'(bus.timeout_err), 32'd1);
    chk("tmo_ctl", ctl(), NONE);
    bus.mem_ready = 1'b1;
    tick();
    chk("halt_stay_state", 32'(bus.state), 32'd5);
    chk("halt_stay_ctl", ctl(), NONE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rec_state", 32'(bus.state), 32'd0);
    chk("rec_timeout", 32'(bus.timeout_err), 32'd0);
    chk("rec_ctl", ctl(), MR | IRW | PCW);
    chk_ret("rec_ret");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
